aes_key_schedule_seq: RTL
=========================

// Module: aes_key_schedule_seq
// PURPOSE
//  Sequential AES-256 key-schedule engine placed upstream of the AES-256 decipher datapath.
//  - Accepts one 256-bit cipher key.
//  - Expands it into 15 round keys at one expansion step per cycle.
//  - Stores the round keys and serves them by round index, so the decipher can read rk14 down to rk0.
//  - Replaces a fully unrolled combinational expansion with 7 iterations of one shared step.
// PARAMETERS
//  RD_LATENCY  1   rd_key latency in cycles after rd_idx. 0 = combinational read, 1 = registered read.
// PORTS
//  clk         in   1    single clock; all state updates on the rising edge
//  rst         in   1    synchronous, active-high reset
//  key_in      in   256  cipher key, sampled on accept
//  key_valid   in   1    key_in valid
//  key_ready   out  1    engine idle, can accept a key
//  busy        out  1    expansion in progress
//  done        out  1    one-cycle pulse when all 15 round keys are stored
//  keys_valid  out  1    round-key store holds a complete, consistent schedule
//  rd_idx      in   4    round index, 0..14, in encryption order
//  rd_key      out  128  round key rk[rd_idx]
// BEHAVIOUR
//  Reset values: key_ready=1, busy=0, done=0, keys_valid=0, rd_key=0, state=IDLE, step counter=0.
//  Accept: key_valid && key_ready at an edge. The same edge does three things:
//   - rk0 <= key_in[255:128], rk1 <= key_in[127:0]
//   - work register W <= key_in
//   - state -> EXPAND, keys_valid <= 0
//  EXPAND, step s = 0..6, one per cycle:
//   - W' = step(W, Rcon[s]); Rcon = 01,02,04,08,10,20,40 (byte in the MSB of word 0).
//   - Word 0: w0' = w0 ^ SubWord(RotWord(w7)) ^ Rcon.
//   - Words 1..3: wi' = wi ^ w(i-1)'.
//   - Word 4: w4' = w4 ^ SubWord(w3'). No rotate, no Rcon.
//   - Words 5..7: wi' = wi ^ w(i-1)'.
//   - Store rk[2s+2] <= W'[255:128]. For s<6 also store rk[2s+3] <= W'[127:0].
//   - Step 6 computes the full W', but its lower half is discarded (rk15 does not exist).
//  After s=6: state DONE for 1 cycle: done=1, keys_valid <= 1; then state -> IDLE.
//   - Accept to done pulse: 8 cycles.
//   - key_ready is low from the cycle after accept through the DONE cycle.
//  FSM transitions: IDLE -(accept)-> EXPAND -(s==6)-> DONE -> IDLE. busy=1 only in EXPAND.
//  key_ready = (state==IDLE). key_valid while not ready is ignored; nothing is queued.
//  keys_valid stays high until the next accept or rst.
//  Read port:
//   - Independent of the FSM.
//   - rd_idx > 14 returns 128'h0.
//   - Reads during EXPAND return the stored value, which may be stale. Consumers gate on keys_valid.
//  rst mid-expansion: FSM -> IDLE, keys_valid=0, step counter cleared. No done pulse.
//  Accept in the same cycle as rst: rst wins, the key is dropped.
//  Byte order matches FIPS-197: key_in[255:248] is key byte 0.
//  S-box: combinational lookup, 8 instances shared by word 0 and word 4 of the step.
// CONFIGURATION
//  AES_KEYSCHED_ZEROIZE_EN defined:
//   - rst and every accept clear all 15 rk registers and W to 0.
//   - The accept clear is overridden by the rk0/rk1 loads on the same edge.
//   - Any rd_idx then returns 0 until it is rewritten.
//  AES_KEYSCHED_ZEROIZE_EN undefined:
//   - rk registers and W carry no reset and keep old contents.
//   - Only the control registers and rd_key reset.
// TESTING
//  1. FIPS-197 key 000102..1f, accept -> done exactly 8 cycles later.
//     rk1=101112131415161718191a1b1c1d1e1f, rk2=a573c29fa176c498a97fce93a572c09c,
//     rk14=24fc79ccbf0979e9371ac23c6d68de36.
//  2. Hold key_valid=1 with a second key during EXPAND -> no second accept, rk14 unchanged.
//     Second key accepted at the first idle cycle after done.
//  3. Assert rst at step 3 -> next cycle keys_valid=0, key_ready=1, busy=0, no done pulse.
//     Then re-run case 1 and check its results.
//  4. rd_idx=15 -> rd_key=0 after RD_LATENCY cycles.
//     Sweep rd_idx 14..0 -> rd_key matches a golden model, one key per cycle.
//  5. Key all-ff -> rk14 matches the golden model.
//     Also check done pulses exactly once and keys_valid rises in the done cycle.
//  6. With AES_KEYSCHED_ZEROIZE_EN: after rst, rd_idx=5 -> 0.
//     Without it: the value is preserved across rst.

Source files
------------

// File: rtl/aes_key_schedule_seq.sv
// -----------------------------------------------------------------------------
// aes_key_schedule_seq
//
// Sequential AES-256 key-schedule engine. One 256-bit cipher key is accepted,
// then expanded into the 15 round keys rk0..rk14. The engine performs one
// expansion step per clock cycle, so it needs 7 steps. It stores the round keys
// and serves them by round index, which lets a decipher datapath walk
// rk14 down to rk0.
//
// Ports
//   clk         single clock, rising edge
//   rst         synchronous, active-high reset
//   key_in      256-bit cipher key; key_in[255:248] is key byte 0
//   key_valid   key_in valid
//   key_ready   engine idle, a key can be accepted
//   busy        expansion in progress
//   done        one-cycle pulse when all 15 round keys are stored
//   keys_valid  round-key store holds a complete, consistent schedule
//   rd_idx      round index 0..14; values above 14 read as zero
//   rd_key      rk[rd_idx], available RD_LATENCY cycles after rd_idx
//
// Parameter
//   RD_LATENCY  0 = combinational read, 1 = registered read
//
// Optional feature
//   AES_KEYSCHED_ZEROIZE_EN: when defined, rst and every accept wipe the
//   round-key store and the work register. When undefined, those registers
//   have no reset and keep their old contents.
// -----------------------------------------------------------------------------
module aes_key_schedule_seq #(
   parameter int RD_LATENCY = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [255:0] key_in,
   input  logic         key_valid,
   output logic         key_ready,
   output logic         busy,
   output logic         done,
   output logic         keys_valid,
   input  logic [3:0]   rd_idx,
   output logic [127:0] rd_key
);

   // AES forward S-box. Entry 0 is in the most significant byte.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox_f(input logic [7:0] x);
      return SBOX[2047 - 8 * int'(x) -: 8];
   endfunction

   typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [2:0]    step_q, step_d;
   logic          keys_valid_q, keys_valid_d;
   logic [255:0]  w_q, w_d, w_next;
   logic [127:0]  rk_q [0:14];
   logic [127:0]  rk_d [0:14];
   logic          accept, expand_en;
   logic [3:0]    hi_idx, lo_idx;

   assign key_ready  = (state_q == S_IDLE);
   assign busy       = (state_q == S_EXPAND);
   assign done       = (state_q == S_DONE);
   assign keys_valid = keys_valid_q;

   // Reset takes priority over an accept or a step on the same edge, so the
   // store is never written while rst is high.
   assign accept    = key_valid && key_ready && !rst;
   assign expand_en = (state_q == S_EXPAND) && !rst;

   // ---------------------------------------------------------------------
   // One expansion step on the eight-word work register W (w0 = W[255:224]).
   // Bytes 0..3 of the S-box bank serve SubWord(RotWord(w7)) and bytes 4..7
   // serve SubWord(w3'). Each byte position is a separate lookup.
   // ---------------------------------------------------------------------
   logic [31:0] rot_w7, sub_rot, sub_n3, rcon_word;
   logic [31:0] n0, n1, n2, n3, n4, n5, n6, n7;

   assign rot_w7    = {w_q[23:0], w_q[31:24]};
   assign rcon_word = {8'h01 << step_q, 24'h000000};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_sbox
         assign sub_rot[8*gi +: 8] = sbox_f(rot_w7[8*gi +: 8]);
         assign sub_n3[8*gi +: 8]  = sbox_f(n3[8*gi +: 8]);
      end
   endgenerate

   assign n0 = w_q[255:224] ^ sub_rot ^ rcon_word;
   assign n1 = w_q[223:192] ^ n0;
   assign n2 = w_q[191:160] ^ n1;
   assign n3 = w_q[159:128] ^ n2;
   assign n4 = w_q[127:96]  ^ sub_n3;
   assign n5 = w_q[95:64]   ^ n4;
   assign n6 = w_q[63:32]   ^ n5;
   assign n7 = w_q[31:0]    ^ n6;
   assign w_next = {n0, n1, n2, n3, n4, n5, n6, n7};

   // Step s writes rk[2s+2] and rk[2s+3].
   assign hi_idx = {step_q, 1'b0} + 4'd2;
   assign lo_idx = {step_q, 1'b0} + 4'd3;

   // ---------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      step_d       = step_q;
      keys_valid_d = keys_valid_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d      = S_EXPAND;
               step_d       = 3'd0;
               keys_valid_d = 1'b0;
            end
         end
         S_EXPAND: begin
            if (step_q == 3'd6) begin
               state_d      = S_DONE;
               step_d       = 3'd0;
               keys_valid_d = 1'b1;
            end else begin
               step_d = step_q + 3'd1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         step_q       <= 3'd0;
         keys_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         step_q       <= step_d;
         keys_valid_q <= keys_valid_d;
      end
   end

   // ---------------------------------------------------------------------
   // Work register and round-key store
   // ---------------------------------------------------------------------
   always_comb begin
      rk_d = rk_q;
      w_d  = w_q;
`ifdef AES_KEYSCHED_ZEROIZE_EN
      if (accept) begin
         for (int i = 0; i < 15; i++) rk_d[i] = '0;
         w_d = '0;
      end
`endif
      if (accept) begin
         rk_d[0] = key_in[255:128];
         rk_d[1] = key_in[127:0];
         w_d     = key_in;
      end else if (expand_en) begin
         w_d          = w_next;
         rk_d[hi_idx] = w_next[255:128];
         // The last step's lower half would be rk15, which does not exist.
         if (step_q != 3'd6) rk_d[lo_idx] = w_next[127:0];
      end
   end

`ifdef AES_KEYSCHED_ZEROIZE_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 15; i++) rk_q[i] <= '0;
         w_q <= '0;
      end else begin
         rk_q <= rk_d;
         w_q  <= w_d;
      end
   end
`else
   always_ff @(posedge clk) begin
      rk_q <= rk_d;
      w_q  <= w_d;
   end
`endif

   // ---------------------------------------------------------------------
   // Read port. It is independent of the FSM, so reads during an expansion
   // may return stale keys.
   // ---------------------------------------------------------------------
   logic [127:0] rd_sel;
   assign rd_sel = (rd_idx <= 4'd14) ? rk_q[rd_idx] : '0;

   generate
      if (RD_LATENCY == 0) begin : g_rd_comb
         assign rd_key = rd_sel;
      end else begin : g_rd_reg
         logic [127:0] rd_key_q;
         always_ff @(posedge clk) begin
            if (rst) rd_key_q <= '0;
            else     rd_key_q <= rd_sel;
         end
         assign rd_key = rd_key_q;
      end
   endgenerate

endmodule
